// File: rtl/vga_pixel_feed.sv
// Pixel FIFO between a frame producer and the 640x480 timing core.
// Locks onto the SOF word, emits one pixel per active cycle, flags underflow and misaligned SOF.
module vga_pixel_feed #(
  parameter int          DEPTH     = 16,
  parameter logic [11:0] ERR_COLOR = 12'hF0F
) (
  input  logic                         i_VGA_CLOCK,
  input  logic                         i_rst,
  input  logic                         i_de,
  input  logic                         i_hsync,
  input  logic                         i_vsync,
  input  logic [11:0]                  i_px_data,
  input  logic                         i_px_sof,
  input  logic                         i_px_valid,
  output logic                         o_px_ready,
  input  logic                         i_clear_err,
  output logic                         o_de,
  output logic                         o_hsync,
  output logic                         o_vsync,
  output logic [3:0]                   o_r,
  output logic [3:0]                   o_g,
  output logic [3:0]                   o_b,
  output logic                         o_underflow,
  output logic                         o_sof_err,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic [1:0]                   o_dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Producer handshake: a word transfers on any rising edge where
  // i_px_valid && o_px_ready; ready depends only on occupancy and reset.
  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  state_t        state_q, state_d;
  logic          first_pix_q, first_pix_d;
  logic          de_q, hsync_q, vsync_q;
  logic [11:0]   pix_q, pix_d;
  logic          underflow_q, sof_err_q;
  logic          fifo_empty, head_sof, push, pop, uf_set, se_set;
  logic [11:0]   head_data;

  assign fifo_empty            = (level_q == '0);
  assign {head_sof, head_data} = mem_q[rd_ptr_q];
  assign o_px_ready            = !i_rst && (level_q < LW'(DEPTH));
  assign push                  = i_px_valid && o_px_ready;

  always_comb begin
    state_d     = state_q;
    first_pix_d = first_pix_q;
    pop         = 1'b0;
    uf_set      = 1'b0;
    se_set      = 1'b0;
    pix_d       = i_de ? ERR_COLOR : 12'h000;
    case (state_q)
      ST_ALIGN: begin
        if (!fifo_empty) begin
          if (head_sof) state_d = ST_ARMED;
          else          pop     = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!i_vsync) begin
          state_d     = ST_RUN;
          first_pix_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_de) begin
          if (fifo_empty) begin
            uf_set  = 1'b1;
            state_d = ST_ALIGN;
          end else if (head_sof && !first_pix_q) begin
            // Next frame's SOF arrived early: hold it for the next vsync.
            se_set  = 1'b1;
            state_d = ST_ARMED;
          end else begin
            pop         = 1'b1;
            pix_d       = head_data;
            first_pix_d = 1'b0;
          end
        end else if (!i_vsync && !first_pix_q) begin
          state_d = ST_ALIGN;
        end
      end
      default: state_d = ST_ALIGN;
    endcase
  end

  // Storage is not reset; the pointers and level define what is valid.
  always_ff @(posedge i_VGA_CLOCK) begin
    if (push) mem_q[wr_ptr_q] <= {i_px_sof, i_px_data};
  end

  always_ff @(posedge i_VGA_CLOCK) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= ST_ALIGN;
      first_pix_q <= 1'b0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      pix_q       <= 12'h000;
      underflow_q <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q     <= level_q + LW'(push) - LW'(pop);
      state_q     <= state_d;
      first_pix_q <= first_pix_d;
      de_q        <= i_de;
      hsync_q     <= i_hsync;
      vsync_q     <= i_vsync;
      pix_q       <= pix_d;
      underflow_q <= (underflow_q && !i_clear_err) || uf_set;
      sof_err_q   <= (sof_err_q && !i_clear_err) || se_set;
    end
  end

  assign o_de        = de_q;
  assign o_hsync     = hsync_q;
  assign o_vsync     = vsync_q;
  assign o_r         = pix_q[11:8];
  assign o_g         = pix_q[7:4];
  assign o_b         = pix_q[3:0];
  assign o_underflow = underflow_q;
  assign o_sof_err   = sof_err_q;
  assign o_level     = level_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_vga_pixel_feed.sv
// Bench for vga_pixel_feed: directed table, hand sequences for corner cases,
// then random traffic against a queue-based reference model.
module tb_vga_pixel_feed;
  localparam int          DEPTH = 16;
  localparam logic [11:0] ERR   = 12'hF0F;
  localparam int M_ALIGN = 0, M_ARMED = 1, M_RUN = 2;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic        sof;
    logic [11:0] data;
    logic        de;
    logic        hs;
    logic        vs;
    logic        clr;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic [11:0] col;
    logic [4:0]  level;
    logic [1:0]  st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, de, hs, vs, valid, sof, clr;
  logic [11:0] data;
  logic        px_ready, o_de, o_hs, o_vs, o_uf, o_se;
  logic [3:0]  o_r, o_g, o_b;
  logic [4:0]  o_level;
  logic [1:0]  o_state;

  vga_pixel_feed #(.DEPTH(DEPTH), .ERR_COLOR(ERR)) dut (
    .i_VGA_CLOCK(clk), .i_rst(rst), .i_de(de), .i_hsync(hs), .i_vsync(vs),
    .i_px_data(data), .i_px_sof(sof), .i_px_valid(valid), .o_px_ready(px_ready),
    .i_clear_err(clr), .o_de(o_de), .o_hsync(o_hs), .o_vsync(o_vs),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_underflow(o_uf), .o_sof_err(o_se),
    .o_level(o_level), .o_dbg_state(o_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_dut = 0;
  bit bad_seen = 0;

  // Reference model: FIFO contents as a queue plus the expected registered outputs.
  logic [12:0] exp_q[$];
  int          m_mode = M_ALIGN;
  bit          m_fp, m_uf, m_se, e_de, e_hs = 1, e_vs = 1;
  logic [11:0] e_col;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic in_t mk(logic r, logic v, logic s, logic [11:0] d,
                             logic e, logic vsy, logic c);
    in_t t;
    t.rst = r; t.valid = v; t.sof = s; t.data = d;
    t.de = e; t.hs = 1'b1; t.vs = vsy; t.clr = c;
    return t;
  endfunction

  task automatic model_step(input in_t v);
    bit          pop, acc, uf_set, se_set, fp_n;
    int          mode_n;
    logic [11:0] col;
    if (v.rst) begin
      exp_q.delete();
      m_mode = M_ALIGN; m_fp = 0; m_uf = 0; m_se = 0;
      e_de = 0; e_hs = 1; e_vs = 1; e_col = 12'h000;
      return;
    end
    acc = v.valid && (exp_q.size() < DEPTH);
    pop = 0; uf_set = 0; se_set = 0; col = ERR;
    mode_n = m_mode; fp_n = m_fp;
    if (m_mode == M_ALIGN) begin
      if (exp_q.size() > 0) begin
        if (exp_q[0][12]) mode_n = M_ARMED;
        else              pop = 1;
      end
    end else if (m_mode == M_ARMED) begin
      if (!v.vs) begin mode_n = M_RUN; fp_n = 1; end
    end else begin
      if (v.de) begin
        if (exp_q.size() == 0) begin uf_set = 1; mode_n = M_ALIGN; end
        else if (exp_q[0][12] && !m_fp) begin se_set = 1; mode_n = M_ARMED; end
        else begin col = exp_q[0][11:0]; pop = 1; fp_n = 0; end
      end else if (!v.vs && !m_fp) mode_n = M_ALIGN;
    end
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back({v.sof, v.data});
    m_mode = mode_n; m_fp = fp_n;
    m_uf = (m_uf && !v.clr) || uf_set;
    m_se = (m_se && !v.clr) || se_set;
    e_de = v.de; e_hs = v.hs; e_vs = v.vs;
    e_col = v.de ? col : 12'h000;
  endtask

  // Driver: apply one cycle of inputs, check ready, clock, compare all outputs.
  task automatic step(input in_t v);
    rst = v.rst; valid = v.valid; sof = v.sof; data = v.data;
    de = v.de; hs = v.hs; vs = v.vs; clr = v.clr;
    #1;
    chk("px_ready", 16'(px_ready), 16'(!v.rst && (exp_q.size() < DEPTH)));
    if (v.valid && px_ready) acc_dut++;
    model_step(v);
    @(posedge clk);
    #1;
    chk("de",        16'(o_de), 16'(e_de));
    chk("hsync",     16'(o_hs), 16'(e_hs));
    chk("vsync",     16'(o_vs), 16'(e_vs));
    chk("colour",    16'({o_r, o_g, o_b}), 16'(e_col));
    chk("underflow", 16'(o_uf), 16'(m_uf));
    chk("sof_err",   16'(o_se), 16'(m_se));
    chk("level",     16'(o_level), 16'(exp_q.size()));
    chk("state",     16'(o_state), 16'(m_mode));
    if (o_de && {o_r, o_g, o_b} >= 12'hA00 && {o_r, o_g, o_b} <= 12'hA04) bad_seen = 1;
  endtask

  vec_t tbl[10];
  in_t  idle, rv;

  initial begin
    idle = mk(0, 0, 0, 12'h000, 0, 1, 0);
    // Basic frame start: SOF word locks, vsync arms, four pixels stream out.
    tbl[0] = '{mk(0, 1, 1, 12'h123, 0, 1, 0), 12'h000, 5'd1, 2'd0};
    tbl[1] = '{mk(0, 1, 0, 12'h456, 0, 1, 0), 12'h000, 5'd2, 2'd1};
    tbl[2] = '{mk(0, 1, 0, 12'h789, 0, 1, 0), 12'h000, 5'd3, 2'd1};
    tbl[3] = '{mk(0, 1, 0, 12'hABC, 0, 1, 0), 12'h000, 5'd4, 2'd1};
    tbl[4] = '{mk(0, 0, 0, 12'h000, 0, 0, 0), 12'h000, 5'd4, 2'd2};
    tbl[5] = '{mk(0, 0, 0, 12'h000, 1, 1, 0), 12'h123, 5'd3, 2'd2};
    tbl[6] = '{mk(0, 0, 0, 12'h000, 1, 1, 0), 12'h456, 5'd2, 2'd2};
    tbl[7] = '{mk(0, 0, 0, 12'h000, 1, 1, 0), 12'h789, 5'd1, 2'd2};
    tbl[8] = '{mk(0, 0, 0, 12'h000, 1, 1, 0), 12'hABC, 5'd0, 2'd2};
    tbl[9] = '{mk(0, 0, 0, 12'h000, 0, 1, 0), 12'h000, 5'd0, 2'd2};

    step(mk(1, 0, 0, 12'h000, 1, 1, 0));
    step(mk(1, 0, 0, 12'h000, 0, 1, 0));
    chk("rst_state", 16'(o_state), 16'(M_ALIGN));
    chk("rst_level", 16'(o_level), 16'd0);
    chk("rst_hsync", 16'(o_hs), 16'd1);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].in);
      chk($sformatf("tbl%0d_col", i), 16'({o_r, o_g, o_b}), 16'(tbl[i].col));
      chk($sformatf("tbl%0d_level", i), 16'(o_level), 16'(tbl[i].level));
      chk($sformatf("tbl%0d_state", i), 16'(o_state), 16'(tbl[i].st));
    end

    // Full FIFO backpressure: one pop admits exactly one waiting word.
    step(mk(1, 0, 0, 12'h000, 0, 1, 0));
    for (int i = 0; i < 16; i++) step(mk(0, 1, i == 0, 12'h300 + 12'(i), 0, 1, 0));
    chk("full_level", 16'(o_level), 16'd16);
    step(mk(0, 1, 0, 12'h3FF, 0, 1, 0));
    chk("full_ready", 16'(px_ready), 16'd0);
    acc_dut = 0;
    step(mk(0, 1, 0, 12'h3FF, 0, 0, 0));
    step(mk(0, 1, 0, 12'h3FF, 1, 1, 0));
    step(mk(0, 1, 0, 12'h3FF, 0, 1, 0));
    step(mk(0, 1, 0, 12'h3FF, 0, 1, 0));
    chk("one_accept", 16'(acc_dut), 16'd1);
    chk("refill_level", 16'(o_level), 16'd16);

    // Drain then underflow; clear in the same cycle as the set keeps the flag.
    for (int i = 0; i < 16; i++) step(mk(0, 0, 0, 12'h000, 1, 1, 0));
    step(mk(0, 0, 0, 12'h000, 1, 1, 1));
    chk("uf_colour", 16'({o_r, o_g, o_b}), 16'(ERR));
    chk("uf_flag", 16'(o_uf), 16'd1);
    chk("uf_state", 16'(o_state), 16'(M_ALIGN));
    step(mk(0, 0, 0, 12'h000, 0, 1, 1));
    chk("uf_clear", 16'(o_uf), 16'd0);

    // Early SOF mid-frame: held, flagged, then used as the next first pixel.
    step(mk(1, 0, 0, 12'h000, 0, 1, 0));
    step(mk(0, 1, 1, 12'h5A0, 0, 1, 0));
    step(mk(0, 1, 0, 12'h5A1, 0, 1, 0));
    step(mk(0, 1, 0, 12'h5A2, 0, 1, 0));
    step(mk(0, 1, 1, 12'h5B0, 0, 1, 0));
    step(mk(0, 1, 0, 12'h5B1, 0, 1, 0));
    step(mk(0, 0, 0, 12'h000, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 12'h000, 1, 1, 0));
    step(mk(0, 0, 0, 12'h000, 1, 1, 0));
    chk("se_colour", 16'({o_r, o_g, o_b}), 16'(ERR));
    chk("se_flag", 16'(o_se), 16'd1);
    chk("se_state", 16'(o_state), 16'(M_ARMED));
    step(mk(0, 0, 0, 12'h000, 0, 0, 0));
    step(mk(0, 0, 0, 12'h000, 1, 1, 0));
    chk("se_first", 16'({o_r, o_g, o_b}), 16'h5B0);

    // Stale words ahead of SOF are discarded in ALIGN.
    step(mk(1, 0, 0, 12'h000, 0, 1, 0));
    for (int i = 0; i < 5; i++) step(mk(0, 1, 0, 12'hA00 + 12'(i), 0, 1, 0));
    step(mk(0, 1, 1, 12'h0C0, 0, 1, 0));
    step(idle);
    chk("align_level", 16'(o_level), 16'd1);
    chk("align_state", 16'(o_state), 16'(M_ARMED));
    step(mk(0, 0, 0, 12'h000, 0, 0, 0));
    step(mk(0, 0, 0, 12'h000, 1, 1, 0));
    chk("align_first", 16'({o_r, o_g, o_b}), 16'h0C0);

    // Reset in the middle of a running frame.
    step(mk(1, 0, 0, 12'h000, 0, 1, 0));
    for (int i = 0; i < 12; i++) step(mk(0, 1, i == 0, 12'h600 + 12'(i), 0, 1, 0));
    step(mk(0, 0, 0, 12'h000, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 12'h000, 1, 1, 0));
    chk("pre_rst_level", 16'(o_level), 16'd9);
    step(mk(1, 1, 0, 12'h6FF, 1, 0, 0));
    chk("mrst_level", 16'(o_level), 16'd0);
    chk("mrst_de", 16'(o_de), 16'd0);
    chk("mrst_sync", 16'({o_hs, o_vs}), 16'd3);
    chk("mrst_flags", 16'({o_uf, o_se}), 16'd0);
    chk("mrst_state", 16'(o_state), 16'(M_ALIGN));
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 12'h000, 1, 1, 0));

    // Random traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      rv.rst   = ($urandom_range(0, 499) == 0);
      rv.valid = ($urandom_range(0, 3) != 0);
      rv.sof   = ($urandom_range(0, 15) == 0);
      rv.data  = 12'($urandom_range(0, 12'h9FF));
      rv.de    = ($urandom_range(0, 2) != 0);
      rv.hs    = 1'($urandom_range(0, 1));
      rv.vs    = ($urandom_range(0, 39) != 0);
      rv.clr   = ($urandom_range(0, 29) == 0);
      step(rv);
    end

    chk("discarded_never_shown", 16'(bad_seen), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_feed.md
VGA_PIXEL_FEED -- requirements
Module: vga_pixel_feed

Interface
REQ-001 Parameter DEPTH, default 16, pixel FIFO depth in entries (power of two, >=4).
REQ-002 Parameter ERR_COLOR, default 12'hF0F, RGB444 value driven for pixels not sourced from the FIFO (underflow or SOF error).
REQ-003 i_VGA_CLOCK  in  1  sole clock; all logic on its rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_de, i_hsync, i_vsync  in  1 each  timing from the 640x480 timing core; syncs are active-low.
REQ-006 i_px_data  in  12  pixel {R[3:0],G[3:0],B[3:0]} from the upstream producer.
REQ-007 i_px_sof  in  1  marks the i_px_data word as pixel (0,0) of a frame.
REQ-008 i_px_valid  in  1  producer word valid.
REQ-009 o_px_ready  out  1  FIFO can accept a word this cycle.
REQ-010 i_clear_err  in  1  single-cycle pulse clearing the sticky error flags.
REQ-011 o_de, o_hsync, o_vsync  out  1 each  timing inputs delayed by exactly 1 cycle.
REQ-012 o_r, o_g, o_b  out  4 each  pixel colour aligned with o_de.
REQ-013 o_underflow, o_sof_err  out  1 each  sticky error flags.
REQ-014 o_level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-015 FIFO entries are 13 bits {sof,data}; a push occurs when i_px_valid && o_px_ready; o_px_ready = (o_level < DEPTH) and not in reset.
REQ-016 No write-through bypass: a word pushed in cycle t is poppable no earlier than t+1; push and pop in the same cycle leave o_level unchanged.
REQ-017 States: ALIGN, ARMED, RUN; reset enters ALIGN.
REQ-018 ALIGN: each cycle the head entry is non-empty with sof=0, it is popped and discarded; when the head has sof=1, go ARMED without popping.
REQ-019 ARMED: when i_vsync==0, go RUN and set first_pix=1; the head is not popped in ARMED.
REQ-020 RUN, i_de=1, FIFO non-empty, and (head.sof==0 or first_pix==1): pop the head; the popped data appears on o_r/o_g/o_b next cycle; clear first_pix.
REQ-021 RUN, i_de=1, FIFO empty: no pop; output ERR_COLOR next cycle; set o_underflow; go ALIGN.
REQ-022 RUN, i_de=1, head.sof==1 and first_pix==0: no pop; output ERR_COLOR next cycle; set o_sof_err; go ARMED.
REQ-023 RUN, i_vsync==0 and first_pix==0: go ALIGN; leftover words are discarded until the next SOF.
REQ-024 Whenever i_de=1 and the state is not RUN, output ERR_COLOR next cycle; this does not set any error flag.
REQ-025 Whenever i_de=0, drive o_r/o_g/o_b = 0 next cycle (blanking).
REQ-026 Pixel latency: i_de at cycle t corresponds to o_de and colour at t+1.
REQ-027 A flag set event and i_clear_err in the same cycle leave the flag set.
REQ-028 Pointers wrap modulo DEPTH; o_level never exceeds DEPTH or underflows below 0.

Reset
REQ-029 While i_rst=1 at a clock edge, the block drives the following values and holds them until the first edge with i_rst=0:
- o_de=0, o_hsync=1, o_vsync=1, o_r/o_g/o_b=0.
- o_underflow=0, o_sof_err=0, o_level=0, o_px_ready=0.
- FIFO emptied; state=ALIGN; first_pix=0.
REQ-030 A reset asserted mid-frame discards all FIFO contents within the same cycle, and no pre-reset word is ever output afterwards.

Verification
REQ-031 Push 4 words, sof on word 0 with data 12'h123, with vsync/de idle -> state ARMED, o_level=4; pulse i_vsync=0, then i_de=1 for 4 cycles -> colours 1/2/3, then the next three words on consecutive cycles, no flags.
REQ-032 Fill to 16 words with i_de=0 -> o_px_ready=0; hold i_px_valid=1 and pop 1 -> exactly one new word accepted and o_level stays 16.
REQ-033 In RUN, drain the FIFO and keep i_de=1 -> ERR_COLOR 12'hF0F one cycle later, o_underflow=1, state ALIGN; pulse i_clear_err -> o_underflow=0.
REQ-034 In RUN after 3 pixels, the head becomes a sof word -> no pop, ERR_COLOR, o_sof_err=1, state ARMED; next i_vsync low -> the sof word is output as the first pixel.
REQ-035 Push 5 sof=0 words then a sof word while in ALIGN -> the 5 words are discarded, o_level=1, state ARMED; none of the 5 words ever reaches o_r/o_g/o_b.
REQ-036 Assert i_rst for 1 cycle mid-RUN with o_level=9 -> next cycle o_level=0, o_de=0, o_hsync=o_vsync=1, flags 0, state ALIGN.
